cam_capture_writer: RTL and testbench
=====================================

CAM_CAPTURE_WRITER -- requirements
Module: cam_capture_writer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, width of the SRAM word address.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port sram_select  input  3  buffer selection state A..F from the triple-buffer controller.
REQ-007 SHALL have port cam_vsync  input  1  camera VSYNC, clk-synchronous; high = vertical blanking.
REQ-008 SHALL have port cam_href  input  1  camera HREF, clk-synchronous; high = active line.
REQ-009 SHALL have port cam_byte_valid  input  1  one-cycle strobe per camera byte.
REQ-010 SHALL have port cam_data  input  8  camera byte; valid when cam_byte_valid is high.
REQ-011 SHALL have port wr_bank  output  2  target buffer: X=0, Y=1, Z=2.
REQ-012 SHALL have port wr_addr  output  ADDR_W  SRAM word address.
REQ-013 SHALL have port wr_data  output  16  RGB565 pixel, with the first byte in [15:8].
REQ-014 SHALL have port wr_en  output  1  one-cycle write strobe.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-016 SHALL have port err  output  3  sticky flags: [0] overflow, [1] odd byte count in a line, [2] invalid sram_select.

Function
REQ-017 SHALL implement FSM states IDLE, BLANK, ACTIVE.
- IDLE -> BLANK when cam_vsync=1.
- BLANK -> ACTIVE on the first cycle with cam_vsync=0.
- ACTIVE -> BLANK when cam_vsync=1.
REQ-018 SHALL, on BLANK->ACTIVE, latch the camera buffer from sram_select as follows; mid-frame sram_select changes SHALL be ignored.
- A,B -> X.
- C,D -> Y.
- E,F -> Z.
REQ-019 SHALL, when sram_select is 6 or 7 at the latch point, set err[2] and suppress all wr_en for that frame.
REQ-020 SHALL clear the pixel address counter to 0 and the byte phase to 0 on BLANK->ACTIVE.
REQ-021 SHALL accept a byte only in ACTIVE, with cam_href=1 and cam_byte_valid=1; phase 0 SHALL store the high byte, and phase 1 SHALL complete the pixel.
REQ-022 SHALL assert wr_en exactly one cycle after the phase-1 byte, with wr_addr = pixel counter, wr_data = {high,low}, and wr_bank = latched bank; the counter SHALL then increment by 1.
REQ-023 SHALL hold wr_addr, wr_data and wr_bank stable while wr_en=0.
REQ-024 SHALL, on a falling edge of cam_href with phase=1, discard the pending byte, set err[1] and reset phase to 0.
REQ-025 SHALL, once H_PIXELS*V_LINES pixels are written in a frame, suppress further writes, set err[0] and leave the counter unchanged (no wrap).
REQ-026 SHALL pulse frame_done for one cycle on ACTIVE->BLANK regardless of pixel count; a short frame is not an error.
REQ-027 SHALL ignore a cam_byte_valid coincident with the cam_vsync rising edge; the frame ends that cycle.
REQ-028 SHALL keep err flags set until reset.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, set the following:
- FSM to IDLE.
- wr_en=0, frame_done=0, err=0.
- wr_addr=0, wr_data=0, wr_bank=0.
- Counter and phase to 0.
REQ-030 SHALL, after a mid-frame reset, produce no writes until a full cam_vsync high->low sequence occurs.

Structure
REQ-031 SHALL take buffer codes X/Y/Z, selection codes A..F and the select-to-camera-buffer decode from shared package tri_buffer_pkg, which the triple-buffer controller also uses.
REQ-032 SHALL place byte pairing (phase, high-byte register, pixel-complete strobe, odd-line detection) in sub-module pixel_assembler.

Verification (H_PIXELS=4, V_LINES=2)
REQ-033 SHALL cover a basic frame.
- Stimulus: sram_select=C; vsync 1->0; 2 lines of 8 bytes 0x00..0x0F.
- Response: 8 wr_en pulses with bank=1, addr 0..7 and data 0x0001,0x0203,...,0x0E0F; one frame_done on vsync rise; err=0.
REQ-034 SHALL cover mid-frame select change.
- Stimulus: sram_select=E at frame start, changed to A after 3 pixels.
- Response: all writes have bank=2.
REQ-035 SHALL cover overflow.
- Stimulus: 9 pixels in a frame.
- Response: 8 writes, addr max 7, err[0]=1.
REQ-036 SHALL cover an odd line.
- Stimulus: 7 bytes, then href falls.
- Response: 3 writes, err[1]=1; the next line starts at phase 0, addr 3.
REQ-037 SHALL cover an invalid select.
- Stimulus: sram_select=7 at vsync fall, full frame.
- Response: no wr_en, err[2]=1, frame_done still pulses.
REQ-038 SHALL cover mid-frame reset.
- Stimulus: reset after 2 pixels, stream continues with vsync low.
- Response: no writes until the next vsync high->low; the following frame writes addr 0 first.

Source files
------------

// File: rtl/tri_buffer_pkg.sv
// Shared triple-buffer definitions.
// Provides the SRAM buffer codes (X/Y/Z) and the controller's selection-state
// codes (A..F). It also provides the decode from selection state to the buffer
// the camera writes into. The triple-buffer controller uses the same package,
// so both sides agree on the encoding.
package tri_buffer_pkg;

  typedef enum logic [1:0] {
    BUF_X = 2'd0,
    BUF_Y = 2'd1,
    BUF_Z = 2'd2
  } buf_e;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5
  } sel_e;

  // Codes 6 and 7 are not states the controller can be in.
  function automatic logic sel_is_valid(input logic [2:0] sel);
    return sel <= 3'(SEL_F);
  endfunction

  function automatic buf_e sel_to_cam_buf(input logic [2:0] sel);
    case (sel)
      3'(SEL_A), 3'(SEL_B): return BUF_X;
      3'(SEL_C), 3'(SEL_D): return BUF_Y;
      3'(SEL_E), 3'(SEL_F): return BUF_Z;
      default:              return BUF_X;
    endcase
  endfunction

endpackage

// File: rtl/cam_capture_writer_if.sv
// Byte-stream bus between the capture FSM and the pixel assembler.
//   href/byte_valid/data : camera line-valid, byte strobe and byte
//   en                   : bytes and line ends count only while en is high
//   clear                : restart byte pairing at frame start
//   pix_vld/pix_data     : strobe and {high,low} word for a completed pixel
//   odd_line             : line ended with an unpaired byte
// master = capture FSM side, slave = pixel assembler side.
interface cam_capture_writer_if;
  logic        href;
  logic        byte_valid;
  logic [7:0]  data;
  logic        en;
  logic        clear;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic        odd_line;

  modport master (
    output href, byte_valid, data, en, clear,
    input  pix_vld, pix_data, odd_line
  );

  modport slave (
    input  href, byte_valid, data, en, clear,
    output pix_vld, pix_data, odd_line
  );
endinterface

// File: rtl/pixel_assembler.sv
// Pairs camera bytes into RGB565 pixels, with the first byte in the high half.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   pa         : byte stream in, pixel strobe and odd-line flag out
// pix_vld is combinational in the cycle of the second byte. The capture
// writer registers it, so the write appears one cycle after that byte.
module pixel_assembler (
  input  logic                 clk,
  input  logic                 reset,
  cam_capture_writer_if.slave  pa
);

  logic       phase_p0;
  logic       href_p0;
  logic [7:0] hi_p0;
  logic       take;
  logic       href_fall;

  assign take      = pa.en && pa.href && pa.byte_valid;
  assign href_fall = href_p0 && !pa.href;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_p0 <= 1'b0;
      href_p0  <= 1'b0;
    end else begin
      href_p0 <= pa.href;
      if (pa.clear) begin
        phase_p0 <= 1'b0;
      end else if (pa.en && href_fall) begin
        // A line that ends mid-pixel drops the dangling high byte.
        phase_p0 <= 1'b0;
      end else if (take) begin
        phase_p0 <= ~phase_p0;
      end
    end
  end

  // p0 -> pixel complete: high byte held until its partner arrives
  always_ff @(posedge clk) begin
    if (take && !phase_p0) begin
      hi_p0 <= pa.data;
    end
  end

  assign pa.pix_vld  = take && phase_p0;
  assign pa.pix_data = {hi_p0, pa.data};
  assign pa.odd_line = pa.en && href_fall && phase_p0;

endmodule

// File: rtl/cam_capture_writer.sv
// Camera capture writer. It turns the camera's VSYNC/HREF byte stream into
// RGB565 SRAM word writes aimed at the buffer chosen by the triple-buffer
// controller at the start of each frame.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   sram_select         : controller selection state A..F (6/7 invalid)
//   cam_vsync, cam_href : frame blanking / active line
//   cam_byte_valid, cam_data : camera byte strobe and byte
//   wr_bank, wr_addr, wr_data, wr_en : registered SRAM write port
//   frame_done          : one-cycle pulse when the active frame ends
//   err                 : sticky [0] overflow, [1] odd line, [2] bad select
module cam_capture_writer
  import tri_buffer_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sram_select,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_valid,
  input  logic [7:0]        cam_data,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic [2:0]        err
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_e;

  // The counter saturates here instead of wrapping into the start of the buffer.
  localparam logic [ADDR_W-1:0] PIX_MAX = ADDR_W'(H_PIXELS * V_LINES);

  state_e            state, state_nxt;
  logic              frame_start;
  logic              frame_end;
  buf_e              bank_q;
  logic              bad_sel_q;
  logic [ADDR_W-1:0] pix_cnt;
  logic              pix_full;
  logic              can_write;

  cam_capture_writer_if pa_bus ();

  // A byte arriving with the VSYNC rise is dropped: the frame has already ended.
  assign pa_bus.href       = cam_href;
  assign pa_bus.byte_valid = cam_byte_valid;
  assign pa_bus.data       = cam_data;
  assign pa_bus.en         = (state == ACTIVE) && !cam_vsync;
  assign pa_bus.clear      = frame_start;

  pixel_assembler u_pixel_assembler (
    .clk   (clk),
    .reset (reset),
    .pa    (pa_bus)
  );

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE:   if (cam_vsync) state_nxt = BLANK;
      BLANK:  if (!cam_vsync) begin
                state_nxt   = ACTIVE;
                frame_start = 1'b1;
              end
      ACTIVE: if (cam_vsync) begin
                state_nxt = BLANK;
                frame_end = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  assign pix_full  = (pix_cnt == PIX_MAX);
  assign can_write = pa_bus.pix_vld && !bad_sel_q && !pix_full;

  // pixel complete -> p1: registered SRAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 3'b000;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= '0;
      pix_cnt    <= '0;
      bank_q     <= BUF_X;
      bad_sel_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_en      <= can_write;
      frame_done <= frame_end;

      // The bank is fixed for the whole frame; later select changes belong to
      // the controller's next swap, not to this frame.
      if (frame_start) begin
        bank_q    <= sel_to_cam_buf(sram_select);
        bad_sel_q <= !sel_is_valid(sram_select);
        pix_cnt   <= '0;
        if (!sel_is_valid(sram_select)) err[2] <= 1'b1;
      end else if (can_write) begin
        pix_cnt <= pix_cnt + 1'b1;
      end

      if (can_write) begin
        wr_addr <= pix_cnt;
        wr_data <= pa_bus.pix_data;
        wr_bank <= bank_q;
      end

      if (pa_bus.pix_vld && !bad_sel_q && pix_full) err[0] <= 1'b1;
      if (pa_bus.odd_line)                          err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_writer.sv
// Testbench for cam_capture_writer (H_PIXELS=4, V_LINES=2) with randomized
// byte timing and data, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_cam_capture_writer;

  localparam int H = 4, V = 2, AW = 19, TOTAL = H * V;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    sram_select = 3'd0;
  logic          cam_vsync = 1'b0;
  logic [1:0]    wr_bank;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          frame_done;
  logic [2:0]    err;

  cam_capture_writer_if cam_bus ();

  cam_capture_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sram_select    (sram_select),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_bus.href),
    .cam_byte_valid (cam_bus.byte_valid),
    .cam_data       (cam_bus.data),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .frame_done     (frame_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         line;
    logic [7:0] d;
    longint     cyc;
  } byte_t;

  typedef struct {
    logic [1:0]    bank;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    longint        cyc;
  } wr_t;

  byte_t      sent[$];
  wr_t        act[$];
  wr_t        exp_q[$];
  logic [2:0] exp_err = 3'b000;
  int         n_checks = 0, n_errors = 0;
  int         fd_cnt = 0, hold_viol = 0, rst_hold = 2;
  logic [AW+17:0] prev_out = '0;

  // Observe outputs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) act.push_back('{bank: wr_bank, addr: wr_addr, data: wr_data, cyc: cyc});
    if (frame_done === 1'b1) fd_cnt++;
    if (reset) rst_hold = 2;
    else if (rst_hold > 0) rst_hold--;
    else if (wr_en === 1'b0 && {wr_bank, wr_addr, wr_data} !== prev_out) hold_viol++;
    prev_out = {wr_bank, wr_addr, wr_data};
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cam_vsync = 1'b0;
    cam_bus.href = 1'b0;
    cam_bus.byte_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_err = 3'b000;
    tick(1);
  endtask

  task automatic send_byte(input int ln, input logic [7:0] d, input bit rec);
    cam_bus.byte_valid = 1'b1;
    cam_bus.data = d;
    if (rec) sent.push_back('{line: ln, d: d, cyc: cyc});
    tick(1);
    cam_bus.byte_valid = 1'b0;
    cam_bus.data = 8'($urandom);
  endtask

  // Reference: pair bytes within each line, number pixels across the frame,
  // keep the first TOTAL, bank = select/2, write one cycle after byte two.
  task automatic build_expected(input logic [2:0] sel, input bit tail, input int last_line);
    int         pix = 0;
    int         cur = -1;
    bit         have_hi = 0;
    logic [7:0] hi = 8'h00;
    exp_q.delete();
    foreach (sent[i]) begin
      if (sent[i].line != cur) begin
        if (have_hi) exp_err[1] = 1'b1;
        have_hi = 0;
        cur = sent[i].line;
      end
      if (!have_hi) begin
        hi = sent[i].d;
        have_hi = 1;
      end else begin
        have_hi = 0;
        if (sel < 3'd6) begin
          if (pix < TOTAL) begin
            exp_q.push_back('{bank: 2'(sel / 2), addr: AW'(pix), data: {hi, sent[i].d}, cyc: sent[i].cyc + 1});
            pix++;
          end else begin
            exp_err[0] = 1'b1;
          end
        end
      end
    end
    // A frame cut off by VSYNC mid-line has no line end inside the frame.
    if (have_hi && !(tail && cur == last_line)) exp_err[1] = 1'b1;
    if (sel >= 3'd6) exp_err[2] = 1'b1;
  endtask

  task automatic run_frame(input logic [2:0] sel, input logic [2:0] sel_mid, input int nlines,
                           input int l0, input int l1, input int l2, input bit pattern, input bit tail);
    int lens[3];
    int k = 0;
    lens = '{l0, l1, l2};
    sent.delete();
    act.delete();
    fd_cnt = 0;
    hold_viol = 0;
    cam_vsync = 1'b1;
    sram_select = sel;
    tick(2 + int'($urandom_range(0, 2)));
    cam_vsync = 1'b0;
    tick(1 + int'($urandom_range(0, 2)));
    for (int ln = 0; ln < nlines; ln++) begin
      cam_bus.href = 1'b1;
      tick(int'($urandom_range(1, 2)));
      for (int b = 0; b < lens[ln]; b++) begin
        if (k == 6) sram_select = sel_mid;
        tick(int'($urandom_range(0, 2)));
        send_byte(ln, pattern ? 8'(k) : 8'($urandom), 1'b1);
        k++;
      end
      if (tail && ln == nlines - 1) begin
        cam_vsync = 1'b1;
        cam_bus.byte_valid = 1'b1;
        cam_bus.data = 8'($urandom);
        tick(1);
        cam_bus.byte_valid = 1'b0;
        cam_bus.href = 1'b0;
      end else begin
        tick(1);
        cam_bus.href = 1'b0;
        tick(2);
      end
    end
    cam_vsync = 1'b1;
    tick(4);
    build_expected(sel, tail, nlines - 1);
    check_eq("n_writes", act.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act.size(); i++) begin
      check_eq("wr_word", {act[i].bank, act[i].addr, act[i].data},
               {exp_q[i].bank, exp_q[i].addr, exp_q[i].data});
      check_eq("wr_cycle", act[i].cyc, exp_q[i].cyc);
    end
    check_eq("frame_done", fd_cnt, 1);
    check_eq("err", err, exp_err);
    check_eq("hold_stable", hold_viol, 0);
  endtask

  initial begin
    cam_bus.href = 1'b0;
    cam_bus.byte_valid = 1'b0;
    cam_bus.data = 8'h00;
    cam_bus.en = 1'b0;
    cam_bus.clear = 1'b0;
    reset = 1'b1;
    tick(3);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_wr_bank", wr_bank, 0);
    reset = 1'b0;
    exp_err = 3'b000;
    tick(1);

    // Basic frame: select C, bytes 0x00..0x0F over two lines.
    run_frame(3'd2, 3'd2, 2, 8, 8, 0, 1'b1, 1'b0);
    if (act.size() == 8) begin
      check_eq("basic_first_data", act[0].data, 16'h0001);
      check_eq("basic_last_data", act[7].data, 16'h0E0F);
      check_eq("basic_last_addr", act[7].addr, 7);
      check_eq("basic_bank", act[3].bank, 1);
    end

    // Select moves from E to A after three pixels.
    run_frame(3'd4, 3'd0, 2, 8, 8, 0, 1'b0, 1'b0);

    // Nine pixels into an eight-pixel frame.
    reset_dut();
    run_frame(3'd1, 3'd1, 2, 8, 10, 0, 1'b0, 1'b0);

    // Seven-byte line followed by a full line.
    reset_dut();
    run_frame(3'd3, 3'd3, 2, 7, 8, 0, 1'b0, 1'b0);

    // Invalid select.
    reset_dut();
    run_frame(3'd7, 3'd7, 2, 8, 8, 0, 1'b0, 1'b0);

    // Byte coincident with the VSYNC rise after an odd count.
    reset_dut();
    run_frame(3'd5, 3'd5, 2, 8, 5, 0, 1'b0, 1'b1);

    // Mid-frame reset.
    reset_dut();
    act.delete();
    cam_vsync = 1'b1;
    sram_select = 3'd2;
    tick(2);
    cam_vsync = 1'b0;
    tick(1);
    cam_bus.href = 1'b1;
    tick(1);
    for (int b = 0; b < 4; b++) send_byte(0, 8'($urandom), 1'b0);
    tick(2);
    check_eq("pre_rst_writes", act.size(), 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_err = 3'b000;
    tick(1);
    act.delete();
    fd_cnt = 0;
    for (int b = 0; b < 8; b++) send_byte(0, 8'($urandom), 1'b0);
    cam_bus.href = 1'b0;
    tick(2);
    cam_vsync = 1'b1;
    tick(4);
    check_eq("post_rst_writes", act.size(), 0);
    check_eq("post_rst_fdone", fd_cnt, 0);
    check_eq("post_rst_err", err, 0);
    run_frame(3'd0, 3'd0, 2, 8, 8, 0, 1'b0, 1'b0);
    if (act.size() > 0) check_eq("restart_addr", act[0].addr, 0);

    // Random frames; error flags accumulate in the model across frames.
    for (int f = 0; f < 12; f++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      run_frame(s, 3'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
